// File: rtl/display_pkg.sv
// Constants shared by the display scanner and the seven-segment decoder.
// Segment vectors are seg[6:0] = {g,f,e,d,c,b,a}, active-high.
package display_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  // The blank output resets high so no segment is ever driven during reset.
  localparam logic BLANK_RST = 1'b1;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  // The index width must never collapse to zero bits, even for a single digit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Free-running divider: tick is high for one cycle out of every DIV cycles.
module clk_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] pcnt;

  assign tick = (pcnt == CW'(DIV - 1));

  // NOTE: sequential state is always assigned with <= so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || tick) pcnt <= '0;
    else             pcnt <= pcnt + CW'(1);
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a multi-digit seven-segment display.
// The displayed value is swapped only at frame boundaries, so a frame never tears.
module display_scanner
  import display_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
  input  logic                          load,
  input  logic                          blank_lz,
  output logic [DIGIT_W-1:0]            bcd,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          blank,
  output logic                          frame_done
);

  localparam int                VAL_W    = DIGIT_W * NUM_DIGITS;
  localparam int                IDX_W    = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic             tick;
  logic             boundary;
  logic [IDX_W-1:0] idx;
  logic [VAL_W-1:0] shadow;
  logic [VAL_W-1:0] disp;
  logic             pending;

  logic [DIGIT_W-1:0]    nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blanked_vec;
  logic                  any_nz;
  logic                  cur_blanked;

  clk_prescaler #(.DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign boundary = tick && (idx == IDX_LAST);

  // Walk from the most significant digit down, accumulating "some higher nibble is nonzero".
  // NOTE: every always_comb output gets a value before the loop, so no latch can be inferred.
  always_comb begin
    any_nz      = 1'b0;
    blanked_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i]         = disp[i*DIGIT_W +: DIGIT_W];
      any_nz         = any_nz | (|nib[i]);
      blanked_vec[i] = (i != 0) && blank_lz && !any_nz;
    end
  end

  assign cur_blanked = blanked_vec[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      bcd        <= '0;
      digit_sel  <= '0;
      blank      <= BLANK_RST;
      frame_done <= 1'b0;
    end else begin
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

      if (load) shadow <= value_in;

      // A load landing on the boundary itself bypasses shadow and is never left pending.
      if (boundary) begin
        if (load)         disp <= value_in;
        else if (pending) disp <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      bcd        <= nib[idx];
      digit_sel  <= cur_blanked ? '0 : (NUM_DIGITS'(1) << idx);
      blank      <= cur_blanked;
      frame_done <= boundary;
    end
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexing scanner for a common-segment 4-digit seven-segment display. Captures a packed 16-bit hex/BCD value, holds it stable for whole frames, and presents one nibble at a time with a one-hot digit select. The `bcd` output feeds `bcd_decoder` directly, and `digit_sel` drives the digit enables. Optional leading-zero blanking suppresses high-order zero digits.

## Interface
- `CLK_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 2.
- `NUM_DIGITS`, default 4: digits scanned; legal range 1..8.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `value_in`  in  4*NUM_DIGITS  packed nibbles; `[3:0]` = digit 0 (least significant).
- `load`  in  1  single-cycle strobe; captures `value_in`.
- `blank_lz`  in  1  level; 1 enables leading-zero blanking; sampled with each output update.
- `bcd`  out  4  nibble for the currently selected digit; to `bcd_decoder`.
- `digit_sel`  out  NUM_DIGITS  one-hot active-high digit enable; all-zero when blanked.
- `blank`  out  1  1 = current digit is suppressed, so segments must be ignored.
- `frame_done`  out  1  one-cycle pulse when the last digit's slot ends.

## Operation
- Registers:
  - `shadow` holds the last loaded value.
  - `pending` flag.
  - `disp` holds the value currently displayed.
  - Prescaler `pcnt` counts 0..CLK_DIV-1.
  - Digit index `idx` counts 0..NUM_DIGITS-1.
- `load` = 1: `shadow <= value_in` and `pending <= 1`. A later `load` before the frame boundary overwrites `shadow`; the last value wins.
- Tick: `pcnt == CLK_DIV-1`. On a tick, `pcnt <= 0` and `idx` increments. `idx` wraps from NUM_DIGITS-1 to 0.
- Frame boundary: a tick with `idx == NUM_DIGITS-1`.
  - If `pending`, then `disp <= shadow` and `pending <= 0`.
  - If `load` occurs in the same cycle, `value_in` is forwarded to `disp` and `pending` stays 0.
- Display never changes mid-frame, so there is no tearing.
- Blanking: digit i (i ≥ 1) is blanked iff `blank_lz` and `disp` nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- Nibbles 10..15 pass unchanged; the decoder renders them as hex.
- Output registers update every cycle from (`idx`, `disp`, `blank_lz`):
  - `bcd <= disp[idx]`
  - `digit_sel <= blanked ? 0 : 1<<idx`
  - `blank <= blanked`
- `frame_done` is registered and asserts the cycle after the frame-boundary tick.

## Timing
- Reset values:
  - `pcnt`, `idx`, `disp`, `shadow`, `pending` = 0.
  - `bcd` = 0, `digit_sel` = 0, `blank` = 1, `frame_done` = 0.
- First cycle after `rst` falls: `digit_sel` = 1 (digit 0), `bcd` = 0, `blank` = 0.
- Output latency: outputs lag `idx` by exactly 1 cycle. Each digit is shown for exactly CLK_DIV cycles. Frame period is NUM_DIGITS*CLK_DIV cycles.
- Load-to-display latency: from 1 cycle (load on the boundary tick) up to NUM_DIGITS*CLK_DIV cycles. New `disp` appears at the output 1 cycle after the boundary, on digit 0.
- `rst` mid-frame: all state returns to reset values on the next edge, including any pending load, which is discarded. A `load` asserted together with `rst` is ignored.
- `blank_lz` toggling mid-frame takes effect on the next output update; it does not wait for the frame boundary.
- NUM_DIGITS = 1: every tick is a frame boundary, and `frame_done` pulses every CLK_DIV cycles.

## Structure
- Shared package/header `display_pkg`: `DIGIT_W` = 4 and the reset constant for `blank`. The same header carries the segment bit order (g..a, active-high) shared with `bcd_decoder`.
- One sub-module: `clk_prescaler` (parameter `DIV`; ports `clk`, `rst`, `tick`). It is reusable for other timing in the design.
- Blanking uses combinational per-digit "all higher nibbles zero" logic, built as a suffix-OR chain over `disp`.

## Test plan
(All scenarios use CLK_DIV=4, NUM_DIGITS=4.)
- **Reset:** hold `rst` 3 cycles, then release → `digit_sel` sequence 0001, 0010, 0100, 1000, each 4 cycles, all `bcd`=0, `frame_done` pulse every 16 cycles.
- **Load, no blanking:** load 0x1234 mid-frame, `blank_lz`=0 → unchanged (0) until the boundary. Next frame shows `bcd` 4, 3, 2, 1 on digits 0..3.
- **Leading-zero blanking:** load 0x0042, `blank_lz`=1 → digits 0 and 1 show 2 and 4. Digits 2 and 3 have `blank`=1 and `digit_sel`=0. With `disp`=0x0000, only digit 0 is shown, as 0.
- **Last load wins / boundary load:** load 0xBEEF, then 0x00A5 in the same frame → only 0x00A5 is displayed. A load of 0x9999 on the boundary-tick cycle appears on the very next frame.
- **Reset mid-frame:** pending load 0x5555, assert `rst` → outputs return to reset values and 0x5555 is never displayed.
- **Blank toggle:** `disp`=0x0007, toggle `blank_lz` 0→1 during digit 2's slot → `blank` rises on the next cycle, not at the frame boundary.
